// File: rtl/cla_share_ctrl_pkg.sv
// Shared definitions for the cla_share_ctrl slice: FSM state encoding,
// requester IDs, adder half width and the signed-overflow helper.
package cla_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    RESP = 2'b11
  } state_t;

  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam int   HALF_W = 16;

  // Two's-complement overflow: operands share a sign and the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
// Ports: a, b (16-bit operands), cin -> s (16-bit sum), cout (carry out of bit 15).
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    // Carries inside a group are expanded from the group's incoming carry;
    // the group-out carry uses group generate/propagate terms.
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    s    = p ^ c[15:0];
    cout = c[16];
  end

endmodule

// File: rtl/cla_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. A lone request is granted directly; when both
// request, the one not served last wins. last_served is updated on accept.
// Ports: clk, rst, req0/req1 (requests), accept/accept_id (grant taken and by
// whom) -> gnt0/gnt1 (one-hot or zero grant).
module rr_arb2
  import cla_share_ctrl_pkg::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  input  logic accept_id,
  output logic gnt0,
  output logic gnt1
);

  logic last_served;

  // Resetting to the other requester makes INIT_PRIO win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_served <= ~INIT_PRIO;
    else if (accept) last_served <= accept_id;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last_served == REQ0) gnt1 = 1'b1;
      else                     gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/cla_share_ctrl.sv
// Shares one cla_16 between two requesters. Narrow ops take one adder pass,
// wide ops take two (low half, then high half with carry held in c_r).
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high; valid never waits on ready, and a held rsp_valid keeps all rsp_*
// stable until rsp_ready.
// Ports: clk, rst; req0_*/req1_* (valid, ready, a, b, cin, wide);
// rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/rsp_ovf; busy; dbg_state (FSM).
module cla_share_ctrl
  import cla_share_ctrl_pkg::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_wide,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  state_t              state, state_nx;
  logic [31:0]         a_r, b_r, sum_r;
  logic                cin_r, wide_r, id_r, c_r, cout_r, ovf_r;
  logic                gnt0, gnt1, accept, accept_id;
  logic [HALF_W-1:0]   add_a, add_b, add_s;
  logic                add_cin, add_cout;

  rr_arb2 #(.INIT_PRIO(INIT_PRIO)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0_valid),
    .req1      (req1_valid),
    .accept    (accept),
    .accept_id (accept_id),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign accept_id  = req1_ready;

  // Only HI uses the upper halves and the chained carry.
  always_comb begin
    add_a   = a_r[HALF_W-1:0];
    add_b   = b_r[HALF_W-1:0];
    add_cin = cin_r;
    if (state == HI) begin
      add_a   = a_r[31:HALF_W];
      add_b   = b_r[31:HALF_W];
      add_cin = c_r;
    end
  end

  cla_16 u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LO;
      LO:      state_nx = wide_r ? HI : RESP;
      HI:      state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      cin_r  <= 1'b0;
      wide_r <= 1'b0;
      id_r   <= 1'b0;
      sum_r  <= '0;
      c_r    <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          a_r    <= accept_id ? req1_a    : req0_a;
          b_r    <= accept_id ? req1_b    : req0_b;
          cin_r  <= accept_id ? req1_cin  : req0_cin;
          wide_r <= accept_id ? req1_wide : req0_wide;
          id_r   <= accept_id;
        end
        LO: begin
          sum_r[HALF_W-1:0] <= add_s;
          c_r               <= add_cout;
          if (!wide_r) begin
            sum_r[31:HALF_W] <= '0;
            cout_r           <= add_cout;
            ovf_r            <= add_ovf(a_r[HALF_W-1], b_r[HALF_W-1], add_s[HALF_W-1]);
          end
        end
        HI: begin
          sum_r[31:HALF_W] <= add_s;
          cout_r           <= add_cout;
          ovf_r            <= add_ovf(a_r[31], b_r[31], add_s[HALF_W-1]);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_ovf   = ovf_r;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cla_share_ctrl.sv
// Directed testbench for cla_share_ctrl with hand-computed expected values.
module tb_cla_share_ctrl;
  import cla_share_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req0_ready, req0_cin = 0, req0_wide = 0;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic        req1_valid = 0, req1_ready, req1_cin = 0, req1_wide = 0;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [31:0] rsp_sum;
  logic [1:0]  dbg_state;

  cla_share_ctrl #(.INIT_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin), .req1_wide(req1_wide),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];   // {id, sum}

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic wide);
    if (id == REQ1) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_wide = wide;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_wide = wide;
    end
  endtask

  function automatic logic ready_of(input logic id);
    return (id == REQ1) ? req1_ready : req0_ready;
  endfunction

  // Called just after a falling edge. Latency counts the accept cycle as 0.
  task automatic do_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic wide, input logic [31:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf, input int hold);
    int t;
    int lat;
    rsp_ready = (hold == 0);
    set_req(id, 1'b1, a, b, cin, wide);
    #1;
    t = 0;
    while (!ready_of(id) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 20) begin
      check_eq({tag, "_accept_timeout"}, 32'(ready_of(id)), 32'd1);
      set_req(id, 1'b0, a, b, cin, wide);
      rsp_ready = 1'b1;
      return;
    end
    check_eq({tag, "_other_ready"}, 32'(ready_of(~id)), 32'd0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Operands may change freely once accepted.
    set_req(id, 1'b0, 32'hDEAD_BEEF, 32'h5A5A_A5A5, ~cin, ~wide);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(lat), wide ? 32'd3 : 32'd2);
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
    check_eq({tag, "_sum"}, rsp_sum, exp_sum);
    check_eq({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
    check_eq({tag, "_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, "_hold_sum"}, rsp_sum, exp_sum);
      check_eq({tag, "_hold_flags"}, {29'd0, rsp_id, rsp_cout, rsp_ovf}, {29'd0, id, exp_cout, exp_ovf});
      check_eq({tag, "_hold_readies"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_idle_after"}, {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int          n_acc, n_rsp, cyc;
    bit          drop;
    logic        gid;
    logic [32:0] e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_state", {30'd0, dbg_state}, 32'd0);
    check_eq("reset_outs", {27'd0, rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy}, 32'd0);
    check_eq("reset_sum", rsp_sum, 32'd0);
    @(negedge clk);

    // 1: narrow signed overflow
    do_op("t1", REQ0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b1, 0);
    // 2: wide, carry chained between halves
    do_op("t2", REQ1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 0);
    // 5: narrow ignores upper operand bits
    do_op("t5", REQ0, 32'hABCD_8000, 32'h1234_8000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);
    // wide overflow taken from bit 31
    do_op("wovf", REQ1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 0);

    // 3: both valid right after reset, round robin 0,1,0,1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(REQ0, 1'b1, 32'hFFFF_0001, 32'h0000_0002, 1'b0, 1'b0);
    set_req(REQ1, 1'b1, 32'hFFFF_0100, 32'h0001_0200, 1'b0, 1'b0);
    n_acc = 0; n_rsp = 0; cyc = 0; drop = 0;
    while (n_rsp < 4 && cyc < 80) begin
      #1;
      if (drop) begin
        req0_valid = 1'b0; req1_valid = 1'b0; drop = 0; #1;
      end
      check_eq("rr_one_hot", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rr_unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rr_rsp_id", 32'(rsp_id), 32'(e[32]));
          check_eq("rr_rsp_sum", rsp_sum, e[31:0]);
        end
        n_rsp++;
      end
      if (n_acc < 4 && (req0_ready || req1_ready)) begin
        gid = req1_ready;
        check_eq("rr_order", 32'(gid), 32'(n_acc % 2));
        exp_q.push_back({gid, gid ? 32'h0000_0300 : 32'h0000_0003});
        n_acc++;
        if (n_acc == 4) drop = 1;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("rr_rsp_count", 32'(n_rsp), 32'd4);
    check_eq("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: wrap-around, response held 5 cycles while req1 waits
    set_req(REQ1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    do_op("t4", REQ0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 5);
    check_eq("t4_waiter_ready", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    @(negedge clk);

    // 6: asynchronous reset while in HI
    set_req(REQ1, 1'b1, 32'h1234_0001, 32'h0000_0001, 1'b0, 1'b1);
    #1;
    check_eq("t6_ready", 32'(req1_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    #3;
    check_eq("t6_in_hi", {30'd0, dbg_state}, {30'd0, HI});
    rst = 1'b1;
    #1;
    check_eq("t6_rst_outs", {27'd0, rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy}, 32'd0);
    check_eq("t6_rst_sum", rsp_sum, 32'd0);
    check_eq("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t6_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    end
    do_op("t6_next", REQ0, 32'h0001_0001, 32'h0002_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
